shift_reg_sequencer: RTL and testbench
======================================

# shift_reg_sequencer

Command-driven controller for the 8-bit universal shift register. Accepts load/shift/rotate commands over a valid/ready handshake and drives the register's `mode`, `data_in` and `serial_in` for the required number of cycles. It then captures the register's `data_out` and returns it on a valid/ready response channel. It sits between the bus-side command logic and the register, and is the register's only driver.

## Interface
- `WIDTH`, 8: register width; must equal the controlled register's width.
- `CNT_W`, 4: width of the shift-count field, giving counts 0..2^CNT_W-1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  2: 00 LOAD, 01 SHL, 10 SHR, 11 ROTL.
- `cmd_data`  in  WIDTH: load value, used by LOAD only.
- `cmd_count`  in  CNT_W: number of shift cycles; ignored for LOAD.
- `cmd_fill`  in  1: serial fill bit for SHL/SHR.
- `sr_mode`  out  2: register mode (00 hold, 01 left, 10 right, 11 load).
- `sr_data_in`  out  WIDTH: register parallel load value.
- `sr_serial_in`  out  1: register serial input.
- `sr_data_out`  in  WIDTH: register current contents.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_data`  out  WIDTH: captured register value.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, RUN, CAPTURE, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch op, data, fill and count.
  - Remaining count is set to 1 for LOAD and to `cmd_count` otherwise.
  - Next state: RUN if remaining ≠ 0, else CAPTURE.
- **RUN**
  - `sr_mode` = op code: 11 for LOAD, 01 for SHL, 01 for ROTL, 10 for SHR.
  - Remaining decrements each cycle; on the last cycle (remaining = 1) the next state is CAPTURE.
- **CAPTURE**
  - `sr_mode`=00; `rsp_data` <= `sr_data_out`; next state is RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data` is held stable.
  - On `rsp_ready`, go to IDLE.
- **Serial input**
  - `sr_serial_in` is fill_q during SHL/SHR RUN cycles.
  - During ROTL RUN cycles it is combinationally `sr_data_out[WIDTH-1]`, giving a true rotate.
  - It is 0 in all other states.
- **Parallel input**
  - `sr_data_in` is data_q during LOAD RUN and 0 otherwise.
- **Output decode**
  - `sr_mode` and `sr_data_in` decode from registered state only; there is no combinational path from `cmd_*`.
- **Boundary conditions**
  - Count 0 (SHL/SHR/ROTL) performs no mode pulses and returns the current contents.
  - Count wrap: the remaining-count register is CNT_W bits wide and never underflows; RUN is never entered with 0.
  - `cmd_valid` outside IDLE is ignored; `cmd_ready`=0 there. The command is not latched.
  - A new command is accepted at the earliest on the cycle after the RESP handshake; there is no back-to-back overlap.
  - The sequencer never resets the register itself.

## Timing
- Command accepted at edge T.
- Active mode cycles are T+1..T+N, where N = 1 for LOAD and N = count otherwise.
- CAPTURE is cycle T+N+1.
- `rsp_valid` rises at T+N+2. With count 0, CAPTURE is T+1 and `rsp_valid` is at T+2.
- Minimum command-to-command spacing is N+3 cycles.
- Reset (any state, including mid-RUN):
  - Next edge: state IDLE.
  - `sr_mode`=00, `sr_data_in`=0, `sr_serial_in`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `cmd_ready`=0 while `reset` is high and 1 from the first cycle after release.
  - An in-flight command and any pending response are discarded; the register keeps whatever shifts already occurred.

## Configuration
- `SHIFT_SEQ_ABORT_EN` defined:
  - Adds input port `abort` (1 bit), placed after `cmd_fill`.
  - `abort`=1 in RUN forces the next state to CAPTURE; the current cycle's shift still occurs.
  - The response then carries the partially shifted value.
  - `abort` in other states is ignored.
- Undefined: no `abort` port; RUN always completes the full count.

## Test plan
- **LOAD:** LOAD `cmd_data`=0xA5 accepted at T -> `sr_mode`=11, `sr_data_in`=0xA5 for exactly cycle T+1; `rsp_valid` at T+3 with `rsp_data`=0xA5.
- **SHL with fill 1:** register 0x81, SHL count 3, fill 1 -> `sr_mode`=01 for 3 cycles, `sr_serial_in`=1 in each; `rsp_data`=0x0F at T+5.
- **SHR with fill 0, then ROTL:**
  - Register 0xF0, SHR count 2, fill 0 -> `rsp_data`=0x3C.
  - Then ROTL count 9 on 0x81 -> `rsp_data`=0x03, with 9 mode-01 cycles observed.
- **Count 0 with backpressure:** SHL count 0 on 0x5A, `rsp_ready` held low 5 cycles -> no mode pulse; `rsp_valid` at T+2 with 0x5A stable throughout. `cmd_ready`=0 and `busy`=1 until the handshake; a `cmd_valid` pulse during RESP is ignored.
- **Reset mid-RUN:** SHL count 10, `reset` pulsed during the 4th RUN cycle -> next cycle `sr_mode`=00, `rsp_valid`=0, `busy`=0; `cmd_ready`=1 on the first cycle after release, and no response is emitted.
- **Abort (with `SHIFT_SEQ_ABORT_EN`):** register 0x01, SHL count 8, fill 0, `abort` during the 3rd RUN cycle -> 3 shifts total; `rsp_data`=0x08 at CAPTURE+1.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for an 8-bit universal shift register: runs load/shift/rotate
// commands and returns the resulting contents. Optional abort input: SHIFT_SEQ_ABORT_EN.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             sr_serial_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StCapture, StResp} state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpShl  = 2'b01;
  localparam logic [1:0] OpShr  = 2'b10;
  localparam logic [1:0] OpRotl = 2'b11;

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeLeft  = 2'b01;
  localparam logic [1:0] ModeRight = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpLoad;
      data_q     <= '0;
      fill_q     <= 1'b0;
      remain_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      fill_q     <= fill_d;
      remain_q   <= remain_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    fill_d     = fill_q;
    remain_d   = remain_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          fill_d   = cmd_fill;
          remain_d = (cmd_op == OpLoad) ? CNT_W'(1) : cmd_count;
          state_d  = (remain_d != '0) ? StRun : StCapture;
        end
      end
      StRun: begin
        remain_d = remain_q - CNT_W'(1);
        // Abort still lets this cycle's shift land; the response shows the partial result.
        if (remain_q == CNT_W'(1) || abort_hit) begin
          remain_d = '0;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        rsp_data_d = sr_data_out;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Register drive decodes from latched command state only.
  always_comb begin
    sr_mode      = ModeHold;
    sr_data_in   = '0;
    sr_serial_in = 1'b0;
    if (state_q == StRun) begin
      unique case (op_q)
        OpLoad: begin
          sr_mode    = ModeLoad;
          sr_data_in = data_q;
        end
        OpShl: begin
          sr_mode      = ModeLeft;
          sr_serial_in = fill_q;
        end
        OpShr: begin
          sr_mode      = ModeRight;
          sr_serial_in = fill_q;
        end
        OpRotl: begin
          sr_mode      = ModeLeft;
          sr_serial_in = sr_data_out[WIDTH-1];
        end
        default: sr_mode = ModeHold;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer driving a behavioural 8-bit universal shift register.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_count = 4'h0;
  logic       cmd_fill = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [1:0] sr_mode;
  logic [7:0] sr_data_in;
  logic       sr_serial_in;
  logic [7:0] sr_q;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_count    (cmd_count),
    .cmd_fill     (cmd_fill),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .sr_mode      (sr_mode),
    .sr_data_in   (sr_data_in),
    .sr_serial_in (sr_serial_in),
    .sr_data_out  (sr_q),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  // The controlled register; never reset, only ever driven by the sequencer.
  always_ff @(posedge clk) begin
    case (sr_mode)
      2'b01:   sr_q <= {sr_q[6:0], sr_serial_in};
      2'b10:   sr_q <= {sr_serial_in, sr_q[7:1]};
      2'b11:   sr_q <= sr_data_in;
      default: sr_q <= sr_q;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c,
                       input logic f);
    check("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    cmd_fill  = f;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_count = 4'h0;
    cmd_fill  = 1'b0;
  endtask

  task automatic finish_rsp(input string tag, input logic [7:0] exp);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, cmd_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic do_load(input logic [7:0] d);
    issue(2'b00, d, 4'h0, 1'b0);
    check("load_mode", sr_mode, 2'b11);
    check("load_data_in", sr_data_in, d);
    check("load_busy", busy, 1);
    check("load_cmd_ready", cmd_ready, 0);
    tick();
    check("load_capture_mode", sr_mode, 2'b00);
    check("load_capture_data_in", sr_data_in, 0);
    check("load_capture_valid", rsp_valid, 0);
    tick();
    finish_rsp("load", d);
  endtask

  task automatic run_shift(input string tag, input logic [1:0] op, input logic [3:0] n,
                           input logic f, input logic [1:0] mode, input logic [7:0] exp);
    issue(op, 8'h00, n, f);
    for (int i = 0; i < int'(n); i++) begin
      check({tag, "_mode"}, sr_mode, mode);
      check({tag, "_serial"}, sr_serial_in, (op == 2'b11) ? sr_q[7] : f);
      tick();
    end
    check({tag, "_capture_mode"}, sr_mode, 2'b00);
    check({tag, "_capture_valid"}, rsp_valid, 0);
    tick();
    finish_rsp(tag, exp);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", sr_mode, 2'b00);
    check("rst_data_in", sr_data_in, 0);
    check("rst_serial", sr_serial_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    do_load(8'hA5);

    do_load(8'h81);
    run_shift("shl3", 2'b01, 4'd3, 1'b1, 2'b01, 8'h0F);

    do_load(8'hF0);
    run_shift("shr2", 2'b10, 4'd2, 1'b0, 2'b10, 8'h3C);

    do_load(8'h81);
    run_shift("rotl9", 2'b11, 4'd9, 1'b0, 2'b01, 8'h03);

    // Count 0 with response backpressure and an ignored command during RESP
    do_load(8'h5A);
    issue(2'b01, 8'h00, 4'd0, 1'b1);
    check("cnt0_capture_mode", sr_mode, 2'b00);
    check("cnt0_capture_valid", rsp_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("cnt0_hold_valid", rsp_valid, 1);
      check("cnt0_hold_data", rsp_data, 8'h5A);
      check("cnt0_hold_ready", cmd_ready, 0);
      check("cnt0_hold_busy", busy, 1);
      check("cnt0_hold_mode", sr_mode, 2'b00);
      if (i == 2) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 8'hFF;
      end
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
    end
    finish_rsp("cnt0", 8'h5A);
    tick();
    check("cnt0_no_latch_busy", busy, 0);
    check("cnt0_reg_kept", sr_q, 8'h5A);

    // Reset during the 4th RUN cycle of SHL 10
    do_load(8'h01);
    issue(2'b01, 8'h00, 4'd10, 1'b0);
    tick();
    tick();
    tick();
    check("rstrun_mode_before", sr_mode, 2'b01);
    reset = 1'b1;
    tick();
    check("rstrun_mode", sr_mode, 2'b00);
    check("rstrun_valid", rsp_valid, 0);
    check("rstrun_busy", busy, 0);
    check("rstrun_cmd_ready", cmd_ready, 0);
    check("rstrun_rsp_data", rsp_data, 0);
    reset = 1'b0;
    tick();
    check("rstrun_rel_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("rstrun_no_rsp", rsp_valid, 0);
      tick();
    end
    check("rstrun_reg_partial", sr_q, 8'h10);

`ifdef SHIFT_SEQ_ABORT_EN
    do_load(8'h01);
    issue(2'b01, 8'h00, 4'd8, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_capture_mode", sr_mode, 2'b00);
    check("abort_capture_valid", rsp_valid, 0);
    tick();
    finish_rsp("abort", 8'h08);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
